// File: rtl/i4003_pkg.sv
// Shared types and default geometry for the i4003 shift-register loader.
package i4003_pkg;

    localparam int DEF_WIDTH = 10;
    localparam int DEF_DIV   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        STROBE = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/i4003_clkdiv.sv
// Shift-clock generator: sr_cp low DIV cycles, high DIV cycles while run is high,
// plus one-cycle ticks flagging the cycle before each rising/falling edge.
module i4003_clkdiv #(
    parameter int DIV = 2
) (
    input  logic cp,
    input  logic rst_n,
    input  logic run,
    output logic sr_cp,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg, cnt_next;
    logic          cp_reg, cp_next;
    logic          wrap;

    always_comb begin
        wrap     = run && (cnt_reg == LAST);
        cnt_next = '0;
        cp_next  = 1'b0;
        // Divider restarts from a low phase whenever it is not running.
        if (run) begin
            cnt_next = wrap ? '0 : cnt_reg + CW'(1);
            cp_next  = wrap ? ~cp_reg : cp_reg;
        end
    end

    always_ff @(posedge cp) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            cp_reg  <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            cp_reg  <= cp_next;
        end
    end

    assign sr_cp     = cp_reg;
    assign rise_tick = wrap && !cp_reg;
    assign fall_tick = wrap && cp_reg;

endmodule

// File: rtl/i4003_loader.sv
// Serial loader for an i4003 shift-register chip: WIDTH shift pulses MSB first, then a latch pulse.
// Define I4003_LOADER_READBACK_EN to capture the chip's previous word from sr_ret into rd_data.
module i4003_loader
    import i4003_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV   = DEF_DIV
) (
    input  logic             cp,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             valid,
    output logic             ready,
    output logic             sr_cp,
    output logic             sr_data,
    output logic             sr_e,
    output logic             busy,
    output logic             done,
    input  logic             sr_ret,
    output logic [WIDTH-1:0] rd_data
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic             sr_data_reg, sr_data_next;
    logic             sr_e_reg, sr_e_next;
    logic             run, rise_tick, fall_tick;

    assign run = (state_reg == SHIFT) || (state_reg == STROBE);

    i4003_clkdiv #(.DIV(DIV)) u_clkdiv (
        .cp        (cp),
        .rst_n     (rst_n),
        .run       (run),
        .sr_cp     (sr_cp),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        sr_data_next = sr_data_reg;
        sr_e_next    = sr_e_reg;
        case (state_reg)
            IDLE: begin
                if (valid) begin
                    // First bit goes out immediately; shift_reg keeps the remaining bits.
                    state_next   = SHIFT;
                    bit_cnt_next = '0;
                    shift_next   = din << 1;
                    sr_data_next = din[WIDTH-1];
                    sr_e_next    = 1'b0;
                end
            end
            SHIFT: begin
                if (fall_tick) begin
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_next   = STROBE;
                        sr_e_next    = 1'b1;
                        sr_data_next = 1'b0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                        sr_data_next = shift_reg[WIDTH-1];
                        shift_next   = shift_reg << 1;
                    end
                end
            end
            STROBE: begin
                if (fall_tick) begin
                    state_next   = FINISH;
                    sr_e_next    = 1'b0;
                    sr_data_next = 1'b0;
                end
            end
            FINISH: begin
                state_next   = IDLE;
                bit_cnt_next = '0;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge cp) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            sr_data_reg <= 1'b0;
            sr_e_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            sr_data_reg <= sr_data_next;
            sr_e_reg    <= sr_e_next;
        end
    end

    assign ready   = (state_reg == IDLE);
    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == FINISH);
    assign sr_data = sr_data_reg;
    assign sr_e    = sr_e_reg;

`ifdef I4003_LOADER_READBACK_EN
    logic [WIDTH-1:0] rd_shift_reg, rd_shift_next;
    logic [WIDTH-1:0] rd_data_reg, rd_data_next;

    // The chip's serial output is stable until sr_cp rises, so sample it on the rise tick.
    always_comb begin
        rd_shift_next = rd_shift_reg;
        rd_data_next  = rd_data_reg;
        if ((state_reg == SHIFT) && rise_tick)
            rd_shift_next = (rd_shift_reg << 1) | WIDTH'(sr_ret);
        if ((state_reg == STROBE) && fall_tick)
            rd_data_next = rd_shift_reg;
    end

    always_ff @(posedge cp) begin
        if (!rst_n) begin
            rd_shift_reg <= '0;
            rd_data_reg  <= '0;
        end else begin
            rd_shift_reg <= rd_shift_next;
            rd_data_reg  <= rd_data_next;
        end
    end

    assign rd_data = rd_data_reg;
`else
    logic unused_ok;
    assign unused_ok = ^{sr_ret, rise_tick};
    assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_i4003_loader.sv
// Directed bench for i4003_loader: two instances (DIV=2, DIV=1), each driving a behavioural i4003 chip.
module tb_i4003_loader;

    logic cp = 1'b0;
    logic rst_n = 1'b0;
    always #5 cp = ~cp;

    logic [9:0] din0, din1, rd_data0, rd_data1;
    logic valid0, ready0, sr_cp0, sr_data0, sr_e0, busy0, done0, sr_ret0;
    logic valid1, ready1, sr_cp1, sr_data1, sr_e1, busy1, done1, sr_ret1;

    i4003_loader #(.WIDTH(10), .DIV(2)) u_dut0 (
        .cp(cp), .rst_n(rst_n), .din(din0), .valid(valid0), .ready(ready0),
        .sr_cp(sr_cp0), .sr_data(sr_data0), .sr_e(sr_e0), .busy(busy0),
        .done(done0), .sr_ret(sr_ret0), .rd_data(rd_data0)
    );

    i4003_loader #(.WIDTH(10), .DIV(1)) u_dut1 (
        .cp(cp), .rst_n(rst_n), .din(din1), .valid(valid1), .ready(ready1),
        .sr_cp(sr_cp1), .sr_data(sr_data1), .sr_e(sr_e1), .busy(busy1),
        .done(done1), .sr_ret(sr_ret1), .rd_data(rd_data1)
    );

`ifdef I4003_LOADER_READBACK_EN
    localparam logic [9:0] RB_EXP = 10'h1C3;
`else
    localparam logic [9:0] RB_EXP = 10'h000;
`endif

    // Chip model: shifts on sr_cp rise when e=0, latches the shift register into q when e=1.
    logic [9:0] sr0 = '0, q0 = '0, sr1 = '0, q1 = '0;
    int pulses0 = 0, e_cnt0 = 0, e_at0 = 0;

    always @(posedge sr_cp0) begin
        pulses0 = pulses0 + 1;
        if (sr_e0) begin
            q0 <= sr0;
            e_cnt0 = e_cnt0 + 1;
            e_at0 = pulses0;
        end else begin
            sr0 <= {sr0[8:0], sr_data0};
        end
    end

    always @(posedge sr_cp1) begin
        if (sr_e1) q1 <= sr1;
        else       sr1 <= {sr1[8:0], sr_data1};
    end

    assign sr_ret0 = sr0[9];
    assign sr_ret1 = sr1[9];

    // Edge monitor: data/enable must not move on an sr_cp rising edge; DIV=1 period must be 2.
    int cyc = 0, viol0 = 0, viol1 = 0, last_rise1 = 0, per_bad1 = 0, per_cnt1 = 0;
    logic p_cp0 = 1'b0, p_d0 = 1'b0, p_e0 = 1'b0, p_cp1 = 1'b0, p_d1 = 1'b0, p_e1 = 1'b0;

    always @(negedge cp) begin
        cyc = cyc + 1;
        if (sr_cp0 && !p_cp0 && (sr_data0 !== p_d0 || sr_e0 !== p_e0)) viol0 = viol0 + 1;
        if (sr_cp1 && !p_cp1) begin
            if (sr_data1 !== p_d1 || sr_e1 !== p_e1) viol1 = viol1 + 1;
            if (last_rise1 != 0) begin
                per_cnt1 = per_cnt1 + 1;
                if (cyc - last_rise1 != 2) per_bad1 = per_bad1 + 1;
            end
            last_rise1 = cyc;
        end
        if (!busy1) last_rise1 = 0;
        p_cp0 = sr_cp0; p_d0 = sr_data0; p_e0 = sr_e0;
        p_cp1 = sr_cp1; p_d1 = sr_data1; p_e1 = sr_e1;
    end

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
    task automatic run0(input logic [9:0] d, input bit hold, output int lat);
        din0 = d; valid0 = 1'b1; lat = 0;
        do begin
            @(negedge cp);
            lat++;
            din0 = ~d;
            if (!hold) valid0 = 1'b0;
        end while (!done0 && lat < 200);
        $display("xfer dut0 din=0x%0h latency=%0d q=0x%0h rd_data=0x%0h", d, lat, q0, rd_data0);
    endtask

    task automatic run1(input logic [9:0] d, output int lat);
        din1 = d; valid1 = 1'b1; lat = 0;
        do begin
            @(negedge cp);
            lat++;
            din1 = ~d;
            valid1 = 1'b0;
        end while (!done1 && lat < 200);
        $display("xfer dut1 din=0x%0h latency=%0d q=0x%0h", d, lat, q1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, p, e, n;
        din0 = '0; valid0 = 1'b0; din1 = '0; valid1 = 1'b0;
        repeat (3) @(negedge cp);
        check("rst_outs0", {26'd0, sr_cp0, sr_data0, sr_e0, busy0, done0, ready0}, 32'h1);
        check("rst_rd0", {22'd0, rd_data0}, 32'h0);
        check("rst_outs1", {26'd0, sr_cp1, sr_data1, sr_e1, busy1, done1, ready1}, 32'h1);
        rst_n = 1'b1;
        repeat (4) @(negedge cp);
        check("idle_quiet0", {26'd0, sr_cp0, sr_data0, sr_e0, busy0, done0, ready0}, 32'h1);

        p = pulses0; e = e_cnt0;
        run0(10'h2A5, 1'b0, lat);
        check("lat_2a5", lat, 45);
        check("q_2a5", q0, 10'h2A5);
        check("pulses_2a5", pulses0 - p, 11);
        check("e_pulse_idx", e_at0 - p, 11);
        check("e_count", e_cnt0 - e, 1);
        check("done_busy_ready", {30'd0, busy0, ready0}, 32'h2);
        @(negedge cp);
        check("ready_after_done", ready0, 1'b1);

        run0(10'h3FF, 1'b1, lat);
        check("lat_b2b_1", lat, 45);
        check("q_b2b_1", q0, 10'h3FF);
        @(negedge cp);
        check("b2b_ready", ready0, 1'b1);
        run0(10'h001, 1'b1, lat);
        valid0 = 1'b0;
        check("lat_b2b_2", lat, 45);
        check("q_b2b_2", q0, 10'h001);
        @(negedge cp);

        run0(10'h0F0, 1'b0, lat);
        check("q_0f0", q0, 10'h0F0);
        @(negedge cp);
        p = pulses0; e = e_cnt0; n = 0;
        din0 = 10'h155; valid0 = 1'b1;
        do begin
            @(negedge cp);
            valid0 = 1'b0;
            n++;
        end while (pulses0 - p < 5 && n < 200);
        check("pulse5_reached", pulses0 - p, 5);
        rst_n = 1'b0;
        @(negedge cp);
        check("abort_outs", {26'd0, sr_cp0, sr_data0, sr_e0, busy0, done0, ready0}, 32'h1);
        check("abort_rd", {22'd0, rd_data0}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge cp);
        check("abort_q", q0, 10'h0F0);
        check("abort_no_strobe", e_cnt0 - e, 0);

        run0(10'h1C3, 1'b0, lat);
        @(negedge cp);
        run0(10'h03C, 1'b0, lat);
        check("lat_rb", lat, 45);
        check("rd_data_rb", {22'd0, rd_data0}, {22'd0, RB_EXP});
        check("q_rb", q0, 10'h03C);
        @(negedge cp);

        run1(10'h000, lat);
        check("lat_div1_a", lat, 23);
        check("q_div1_a", q1, 10'h000);
        @(negedge cp);
        run1(10'h3FF, lat);
        check("lat_div1_b", lat, 23);
        check("q_div1_b", q1, 10'h3FF);
        check("div1_period_bad", per_bad1, 0);
        check("div1_period_cnt", per_cnt1, 20);
        check("setup_viol0", viol0, 0);
        check("setup_viol1", viol1, 0);
        @(negedge cp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
